mem_ctrl_fsm: RTL and testbench
===============================

// Module: mem_ctrl_fsm
// PURPOSE
//  Multicycle sequencer driving the memory subsystem's IorD, wea and IRWrite controls, plus PCWrite.
//  Fetches each instruction (address from PC), decodes IRw[15:12], and runs load/store memory phases
//  (address from ALUout). Hands every other opcode to the execute stage via an exec_start/exec_done handshake.
//  Sits directly upstream of the memory subsystem: it controls the memory port and consumes IR contents.
// PARAMETERS
//  OPC_LOAD     4'h1  opcode: read mem[ALUout] into memOut, then pulse load_wb
//  OPC_STORE    4'h2  opcode: write bWire to mem[ALUout]
//  OPC_HALT     4'hF  opcode: stop sequencing
//  MEM_LAT      1     memory read wait cycles, legal 1..4
//  TIMEOUT_CYC  255   exec_done watchdog limit (used only with EXEC_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock, all state changes on rising edge
//  reset      in   1   synchronous reset, active-low
//  run        in   1   1 = keep fetching; 0 = stop at the next instruction boundary
//  IRw        in   16  instruction register contents; opcode = IRw[15:12]
//  exec_done  in   1   execute stage finished (ALU op or address calculation)
//  IorD       out  1   0 = PC addresses memory, 1 = ALUout addresses memory
//  wea        out  1   memory write enable
//  IRWrite    out  1   IR load enable
//  PCWrite    out  1   PC increment enable
//  exec_start out  1   one-cycle request to the execute stage
//  load_wb    out  1   one-cycle pulse: memOut holds load data
//  halted     out  1   sequencer stopped on HALT (or on a fault)
//  fault      out  1   exec watchdog expired (always 0 without EXEC_TIMEOUT_EN)
// BEHAVIOUR
//  - States: IDLE, FETCH, DECODE, ADDR, MRD, WB, MWR, EXEC, HALT. Moore outputs, decoded from state.
//  - reset=0 at an edge: state=IDLE and all counters cleared. All outputs are 0 in IDLE.
//    Reset mid-operation aborts the instruction; wea is 0 from that edge onward.
//  - IDLE: run=1 -> FETCH; otherwise stay in IDLE.
//  - FETCH: IorD=0 for MEM_LAT cycles (wait counter).
//    IRWrite=1 and PCWrite=1 in the last FETCH cycle only, then -> DECODE.
//  - DECODE (1 cycle, all outputs 0), dispatch on IRw[15:12]:
//    LOAD/STORE -> ADDR; HALT -> HALT; any other opcode -> EXEC.
//  - ADDR, EXEC:
//    - exec_start=1 in the entry cycle only. exec_done is ignored in the entry cycle and sampled every later cycle.
//    - A stray exec_done in any other state is ignored.
//    - ADDR exits on exec_done: LOAD -> MRD, STORE -> MWR.
//    - EXEC exits on exec_done to the boundary.
//  - MRD: IorD=1 for MEM_LAT cycles, then -> WB.
//  - WB: IorD=1 and load_wb=1 for 1 cycle, then to the boundary.
//  - MWR: IorD=1 and wea=1 for exactly 1 cycle, then to the boundary. wea is never asserted in any other state.
//  - Boundary: run=1 -> FETCH, run=0 -> IDLE. run is sampled only in IDLE and at the boundary.
//  - HALT: halted=1, all other outputs 0. Exit only through reset; run is ignored.
//  - Latency, MEM_LAT=1, exec_done in the 2nd exec cycle:
//    ALU op = 4 cycles (F, D, E, E); LOAD = 6 cycles (F, D, A, A, MRD, WB); STORE = 5 cycles.
//  - Opcodes with IRw[15:12] outside the three parameters are treated as ALU class and never fault.
// CONFIGURATION
//  - EXEC_TIMEOUT_EN defined:
//    - An 8-bit-or-wider counter runs in ADDR/EXEC.
//    - If exec_done is not seen within TIMEOUT_CYC cycles after exec_start -> HALT with fault=1 and halted=1.
//    - fault is sticky until reset.
//  - EXEC_TIMEOUT_EN undefined: no counter; ADDR/EXEC wait indefinitely; fault is tied to 0.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with run=1 -> every output 0; state IDLE after release if run=0.
//  - ALU op: run=1, IRw=16'h3000, exec_done 1 cycle after exec_start ->
//    IRWrite/PCWrite high cycle 1, exec_start cycle 3, next FETCH cycle 5.
//  - LOAD: IRw=16'h1004, MEM_LAT=2 -> IorD=1 for 2 MRD cycles plus WB; load_wb exactly 1 pulse; wea stays 0.
//  - STORE then run=0: IRw=16'h2000 -> wea=1 for exactly 1 cycle with IorD=1; next state IDLE; no further IRWrite.
//  - HALT: IRw=16'hF000 -> halted=1 from cycle 3; run toggling ignored; reset pulse clears halted.
//  - Abort: reset=0 during MWR entry, plus stray exec_done in DECODE -> wea stays 0, no state change from stray done.
//  - With EXEC_TIMEOUT_EN, TIMEOUT_CYC=8: exec_done never arrives -> fault=1 and halted=1 at cycle 8 after exec_start.

Source files
------------

// File: rtl/mem_ctrl_fsm.sv
// mem_ctrl_fsm: multicycle fetch / decode / load-store sequencer driving the memory port controls.
// Optional exec-stage watchdog is compiled in when EXEC_TIMEOUT_EN is defined.
module mem_ctrl_fsm #(
  parameter logic [3:0]  OPC_LOAD    = 4'h1,
  parameter logic [3:0]  OPC_STORE   = 4'h2,
  parameter logic [3:0]  OPC_HALT    = 4'hF,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] IRw,
  input  logic        exec_done,
  output logic        IorD,
  output logic        wea,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        exec_start,
  output logic        load_wb,
  output logic        halted,
  output logic        fault
);

  // One counter serves the memory wait phases and the exec watchdog, so it is sized for the larger.
  localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W   = (TO_BITS > 8) ? TO_BITS : 8;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ADDR, MRD, WB, MWR, EXEC, HALT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               entry_q, entry_d;
  logic               is_load_q, is_load_d;
  logic [3:0]         opcode;
  state_e             boundary;
  logic               unused_irw;

  assign opcode     = IRw[15:12];
  assign unused_irw = ^IRw[11:0];

`ifdef EXEC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic fault_q, fault_d;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    entry_d   = 1'b0;
    is_load_d = is_load_q;
    boundary  = run ? FETCH : IDLE;
`ifdef EXEC_TIMEOUT_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (cnt_q == LAT_LAST) begin
          state_d = DECODE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECODE: begin
        cnt_d = '0;
        if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d   = ADDR;
          entry_d   = 1'b1;
          is_load_d = (opcode == OPC_LOAD);
        end else if (opcode == OPC_HALT) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
          entry_d = 1'b1;
        end
      end
      ADDR, EXEC: begin
        // exec_done is only meaningful once the request from the entry cycle is out.
        if (!entry_q && exec_done) begin
          cnt_d = '0;
          if (state_q == EXEC)  state_d = boundary;
          else if (is_load_q)   state_d = MRD;
          else                  state_d = MWR;
        end
`ifdef EXEC_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      MRD: begin
        if (cnt_q == LAT_LAST) begin
          state_d = WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB:      state_d = boundary;
      MWR:     state_d = boundary;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      entry_q   <= 1'b0;
      is_load_q <= 1'b0;
`ifdef EXEC_TIMEOUT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      entry_q   <= entry_d;
      is_load_q <= is_load_d;
`ifdef EXEC_TIMEOUT_EN
      fault_q   <= fault_d;
`endif
    end
  end

  // Moore outputs: a function of the registered state and its wait counter only.
  always_comb begin
    IorD       = 1'b0;
    wea        = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    exec_start = 1'b0;
    load_wb    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite = (cnt_q == LAT_LAST);
        PCWrite = (cnt_q == LAT_LAST);
      end
      ADDR, EXEC: exec_start = entry_q;
      MRD:  IorD = 1'b1;
      WB: begin
        IorD    = 1'b1;
        load_wb = 1'b1;
      end
      MWR: begin
        IorD = 1'b1;
        wea  = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Scoreboard bench for mem_ctrl_fsm: a directed script queues the expected output vector per cycle,
// and an independent negedge monitor pops and compares against what the DUT presents.
module tb_mem_ctrl_fsm;

  localparam int LAT = 2;
  localparam int TO  = 8;

  // Output vector layout: {fault, halted, load_wb, exec_start, PCWrite, IRWrite, wea, IorD}
  localparam logic [7:0] O_IORD = 8'h01;
  localparam logic [7:0] O_WEA  = 8'h02;
  localparam logic [7:0] O_IRW  = 8'h04;
  localparam logic [7:0] O_PCW  = 8'h08;
  localparam logic [7:0] O_XS   = 8'h10;
  localparam logic [7:0] O_LWB  = 8'h20;
  localparam logic [7:0] O_HLT  = 8'h40;
  localparam logic [7:0] O_FLT  = 8'h80;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] IRw;
  logic        exec_done;
  logic        IorD, wea, IRWrite, PCWrite, exec_start, load_wb, halted, fault;
  logic [7:0]  outs;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] outs;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  e;
  string t;

  mem_ctrl_fsm #(
    .OPC_LOAD   (4'h1),
    .OPC_STORE  (4'h2),
    .OPC_HALT   (4'hF),
    .MEM_LAT    (LAT),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .IRw       (IRw),
    .exec_done (exec_done),
    .IorD      (IorD),
    .wea       (wea),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .exec_start(exec_start),
    .load_wb   (load_wb),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign outs = {fault, halted, load_wb, exec_start, PCWrite, IRWrite, wea, IorD};

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (outs !== e.outs) begin
          failures++;
          $display("FAIL %s cyc=%0d outs got=%02h expected=%02h", t, cyc, outs, e.outs);
        end
      end else if (outs !== 8'h00) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output cyc=%0d outs got=%02h expected=00", cyc, outs);
      end
    end
  end

  // Queue what the DUT must show after the next rising edge, then take that edge.
  task automatic step(input logic [7:0] exp_outs, input string tag);
    exp_t r;
    r.cyc  = cyc + 1;
    r.outs = exp_outs;
    exp_q.push_back(r);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] instr);
    IRw = instr;
    for (int i = 0; i < LAT - 1; i++) step(8'h00, "fetch_wait");
    step(O_IRW | O_PCW, "fetch_last");
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; IRw = 16'h0000; exec_done = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) step(8'h00, "reset_hold");
    reset = 1'b1; run = 1'b0;
    step(8'h00, "idle_after_reset");
    step(8'h00, "idle_after_reset");

    // ALU op, done one cycle after exec_start, run stays high into the next fetch
    run = 1'b1;
    fetch(16'h3000);
    step(8'h00, "alu_decode");
    step(O_XS,  "alu_exec_start");
    step(8'h00, "alu_exec_wait");
    exec_done = 1'b1;
    step(8'h00, "alu_next_fetch");
    exec_done = 1'b0;

    // STORE, done held through the ADDR entry cycle (ignored there), run dropped before the boundary
    IRw = 16'h2000;
    step(O_IRW | O_PCW, "store_fetch_last");
    step(8'h00, "store_decode");
    run = 1'b0;
    step(O_XS, "store_addr_start");
    exec_done = 1'b1;
    step(8'h00, "store_entry_done_ignored");
    step(O_IORD | O_WEA, "store_mwr");
    exec_done = 1'b0;
    step(8'h00, "store_to_idle");
    step(8'h00, "store_idle_hold");
    step(8'h00, "store_idle_hold");

    // LOAD with stray exec_done across FETCH/DECODE
    run = 1'b1;
    step(8'h00, "load_fetch_wait");
    IRw = 16'h1004;
    step(O_IRW | O_PCW, "load_fetch_last");
    exec_done = 1'b1;
    step(8'h00, "load_decode_stray");
    step(O_XS, "load_addr_start");
    exec_done = 1'b0;
    step(8'h00, "load_addr_wait");
    exec_done = 1'b1;
    step(O_IORD, "load_mrd");
    exec_done = 1'b0; run = 1'b0;
    for (int i = 1; i < LAT; i++) step(O_IORD, "load_mrd");
    step(O_IORD | O_LWB, "load_wb");
    step(8'h00, "load_to_idle");

    // HALT ignores run; only reset leaves
    run = 1'b1;
    fetch(16'hF000);
    step(8'h00, "halt_decode");
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      step(O_HLT, "halt_hold");
    end
    reset = 1'b0;
    step(8'h00, "halt_reset");
    reset = 1'b1; run = 1'b0;
    step(8'h00, "halt_cleared_idle");

    // Abort: reset on the edge that would enter MWR
    run = 1'b1;
    fetch(16'h2000);
    step(8'h00, "abort_decode");
    step(O_XS, "abort_addr_start");
    exec_done = 1'b1; reset = 1'b0;
    step(8'h00, "abort_reset_no_wea");
    exec_done = 1'b0; reset = 1'b1; run = 1'b0;
    step(8'h00, "abort_idle");
    step(8'h00, "abort_idle");

    // Exec with no done: watchdog if built in, otherwise indefinite wait with fault low
    run = 1'b1;
    fetch(16'h5000);
    step(8'h00, "wd_decode");
    step(O_XS, "wd_exec_start");
`ifdef EXEC_TIMEOUT_EN
    for (int i = 1; i < TO; i++) step(8'h00, "wd_wait");
    step(O_HLT | O_FLT, "wd_fault");
    run = 1'b0;
    step(O_HLT | O_FLT, "wd_fault_sticky");
    reset = 1'b0;
    step(8'h00, "wd_reset_clears");
    reset = 1'b1;
    step(8'h00, "wd_idle");
`else
    run = 1'b0;
    for (int i = 1; i < 3 * TO; i++) step(8'h00, "exec_wait_no_fault");
    exec_done = 1'b1;
    step(8'h00, "exec_done_to_idle");
    exec_done = 1'b0;
    step(8'h00, "exec_idle_hold");
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
